// File: rtl/id_ex_control_stage_pkg.sv
// Shared definitions for the ID->EX control stage.
//   selector                : field encodings of the decoded control word
//   signals                 : control_t, get_clear_control(), stage_state_t
//   id_ex_control_stage_pkg : small helpers shared by the stage and its hazard detector
// No ports; packages only.

package selector;
    localparam logic       DEST_REG_RT       = 1'b0;
    localparam logic       DEST_REG_RD       = 1'b1;

    localparam logic [1:0] REG_SRC_ALU       = 2'd0;
    localparam logic [1:0] REG_SRC_MEM       = 2'd1;
    localparam logic [1:0] REG_SRC_PC        = 2'd2;
    localparam logic [1:0] REG_SRC_HILO      = 2'd3;

    // bit 0 = reads rs, bit 1 = reads rt
    localparam logic [1:0] OPERAND_USE_NONE  = 2'd0;
    localparam logic [1:0] OPERAND_USE_RS    = 2'd1;
    localparam logic [1:0] OPERAND_USE_RT    = 2'd2;
    localparam logic [1:0] OPERAND_USE_RS_RT = 2'd3;
endpackage

package signals;
    typedef struct packed {
        logic       write_reg;
        logic       dest_reg;
        logic [1:0] reg_src;
        logic [1:0] opd_use;
        logic [3:0] alu_op;
        logic       mem_read;
        logic       mem_write;
    } control_t;

    localparam int CTL_W = $bits(control_t);

    function automatic control_t get_clear_control();
        return '0;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        MULTI = 2'd2
    } stage_state_t;
endpackage

package id_ex_control_stage_pkg;
    import signals::*;
    import selector::*;

    function automatic logic reads_rs(input logic [1:0] opd_use);
        return (opd_use == OPERAND_USE_RS) || (opd_use == OPERAND_USE_RS_RT);
    endfunction

    function automatic logic reads_rt(input logic [1:0] opd_use);
        return (opd_use == OPERAND_USE_RT) || (opd_use == OPERAND_USE_RS_RT);
    endfunction

    // Destination index written by an op; 0 means "no register write".
    function automatic logic [4:0] resolve_dest(input control_t c,
                                                input logic [4:0] rt,
                                                input logic [4:0] rd);
        if (!c.write_reg)
            return 5'd0;
        return (c.dest_reg == DEST_REG_RD) ? rd : rt;
    endfunction
endpackage

// File: rtl/id_ex_control_stage_load_use_detector.sv
// load_use_detector: combinational load-use hazard compare.
//   held_valid/held_write/held_src/held_dest : op currently held in the stage
//   in_opd/in_rs/in_rt                        : operand usage and sources of the incoming op
//   hazard                                    : incoming op needs a value the held load has not loaded yet

module load_use_detector
    import selector::*;
    import id_ex_control_stage_pkg::*;
(
    input  logic       held_valid,
    input  logic       held_write,
    input  logic [1:0] held_src,
    input  logic [4:0] held_dest,
    input  logic [1:0] in_opd,
    input  logic [4:0] in_rs,
    input  logic [4:0] in_rt,
    output logic       hazard
);
    logic held_is_load;
    logic rs_match;
    logic rt_match;

    // $zero is never a real dependency, so a load to r0 never stalls.
    assign held_is_load = held_valid & held_write & (held_src == REG_SRC_MEM) & (held_dest != 5'd0);
    assign rs_match     = reads_rs(in_opd) & (in_rs == held_dest);
    assign rt_match     = reads_rt(in_opd) & (in_rt == held_dest);
    assign hazard       = held_is_load & (rs_match | rt_match);
endmodule

// File: rtl/id_ex_control_stage.sv
// id_ex_control_stage: ID->EX pipeline register for the decoded control word.
//   clk, reset_n (async active-low), flush (sync kill)
//   in_valid/in_ready/in_ctl/in_rs/in_rt/in_rd/in_multi : decoder side
//   out_valid/out_ready/out_ctl/out_rs/out_rt/out_dest  : EX side
//   busy      : multi-cycle MUL/DIV op occupies the stage
//   state_dbg : current FSM state
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; valid never depends on ready, and the payload is held stable while
// valid is high and ready is low. While a multi-cycle op runs, out_ready is
// ignored until its last cycle.
// MULDIV_CYCLES must be >= 2 and 2**CNT_W must exceed MULDIV_CYCLES.

module id_ex_control_stage
    import signals::*;
    import id_ex_control_stage_pkg::*;
#(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CTL_W-1:0] in_ctl,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic             in_multi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CTL_W-1:0] out_ctl,
    output logic [4:0]       out_rs,
    output logic [4:0]       out_rt,
    output logic [4:0]       out_dest,
    output logic             busy,
    output stage_state_t     state_dbg
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_CYCLES - 1);

    stage_state_t     state;
    stage_state_t     state_next;
    logic [CNT_W-1:0] cnt;
    control_t         in_c;
    control_t         out_c;
    logic             hazard;
    logic             multi_done;
    logic             in_fire;

    assign in_c    = control_t'(in_ctl);
    assign out_ctl = out_c;

    load_use_detector u_load_use (
        .held_valid (out_valid),
        .held_write (out_c.write_reg),
        .held_src   (out_c.reg_src),
        .held_dest  (out_dest),
        .in_opd     (in_c.opd_use),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .hazard     (hazard)
    );

    // Last counting cycle: from here the multi op behaves like a held op.
    assign multi_done = (state == MULTI) && (cnt == CNT_LAST);

    // Accept into an empty stage, or into a held op that leaves this same cycle.
    assign in_ready = reset_n & ~flush & ~hazard & ~busy &
                      ((state == IDLE) | ((state == HOLD) & out_ready));
    assign in_fire  = in_valid & in_ready;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire)
                        state_next = in_multi ? MULTI : HOLD;
                end
                HOLD: begin
                    if (in_fire)
                        state_next = in_multi ? MULTI : HOLD;
                    else if (out_ready)
                        state_next = IDLE;
                end
                MULTI: begin
                    // Not taken on the last cycle: park in HOLD until EX accepts.
                    if (multi_done)
                        state_next = out_ready ? IDLE : HOLD;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs decoded from state
    always_comb begin
        out_valid = (state != IDLE);
        busy      = (state == MULTI);
        state_dbg = state;
    end

    // Multi-cycle counter: zero on entry to MULTI, counts only while in MULTI.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (flush || in_fire || state != MULTI || multi_done)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // Pipeline register. A new op loaded in HOLD overwrites the one leaving.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_c    <= get_clear_control();
            out_rs   <= 5'd0;
            out_rt   <= 5'd0;
            out_dest <= 5'd0;
        end else if (flush) begin
            out_c    <= get_clear_control();
            out_rs   <= 5'd0;
            out_rt   <= 5'd0;
            out_dest <= 5'd0;
        end else if (in_fire) begin
            out_c    <= in_c;
            out_rs   <= in_rs;
            out_rt   <= in_rt;
            out_dest <= resolve_dest(in_c, in_rt, in_rd);
        end
    end
endmodule

// File: tb/tb_id_ex_control_stage.sv
module tb_id_ex_control_stage;
    import signals::*;
    import selector::*;

    localparam int N = 32;
    localparam int W = CTL_W + 15;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [CTL_W-1:0] in_ctl = '0;
    logic [4:0]       in_rs = '0;
    logic [4:0]       in_rt = '0;
    logic [4:0]       in_rd = '0;
    logic             in_multi = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CTL_W-1:0] out_ctl;
    logic [4:0]       out_rs;
    logic [4:0]       out_rt;
    logic [4:0]       out_dest;
    logic             busy;
    stage_state_t     state_dbg;

    id_ex_control_stage #(.MULDIV_CYCLES(N), .CNT_W(6)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctl(in_ctl),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_multi(in_multi),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctl(out_ctl),
        .out_rs(out_rs), .out_rt(out_rt), .out_dest(out_dest),
        .busy(busy), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // model: one slot holding the op EX will see, plus cycles left in the MUL/DIV unit
    bit               m_valid;
    control_t         m_ctl;
    logic [4:0]       m_rs, m_rt, m_dest;
    int               m_left;
    logic [W-1:0]     exp_q[$];
    bit               last_accept;
    logic             s_in_ready, s_busy, s_valid;

    function automatic bit uses_rs(input logic [1:0] u);
        return u == OPERAND_USE_RS || u == OPERAND_USE_RS_RT;
    endfunction
    function automatic bit uses_rt(input logic [1:0] u);
        return u == OPERAND_USE_RT || u == OPERAND_USE_RS_RT;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_ctl   = get_clear_control();
        m_rs    = 5'd0;
        m_rt    = 5'd0;
        m_dest  = 5'd0;
        m_left  = 0;
        exp_q.delete();
    endtask

    // One clock: compare at negedge, advance the model, return at posedge+1.
    task automatic cycle();
        control_t ic;
        bit hz, exp_busy, exp_ready, leave, accept;
        @(negedge clk);
        ic = control_t'(in_ctl);
        hz = m_valid && m_ctl.write_reg && (m_ctl.reg_src == REG_SRC_MEM) && (m_dest != 5'd0) &&
             ((uses_rs(ic.opd_use) && in_rs == m_dest) || (uses_rt(ic.opd_use) && in_rt == m_dest));
        exp_busy  = (m_left > 0);
        exp_ready = reset_n && !flush && !hz && !exp_busy && (!m_valid || out_ready);
        check("in_ready",  32'(in_ready),  32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("busy",      32'(busy),      32'(exp_busy));
        check("out_ctl",   32'(out_ctl),   32'(m_ctl));
        check("out_rs",    32'(out_rs),    32'(m_rs));
        check("out_rt",    32'(out_rt),    32'(m_rt));
        check("out_dest",  32'(out_dest),  32'(m_dest));
        s_in_ready = in_ready;
        s_busy     = busy;
        s_valid    = out_valid;
        leave  = m_valid && out_ready && (m_left <= 1);
        accept = in_valid && exp_ready;
        last_accept = accept;
        if (!reset_n || flush) begin
            model_reset();
        end else begin
            if (leave) begin
                if (exp_q.size() == 0)
                    check("transfer_queue_empty", 32'(exp_q.size()), 32'd1);
                else
                    check("transfer", 32'({out_ctl, out_rs, out_rt, out_dest}), 32'(exp_q.pop_front()));
            end
            if (accept) begin
                m_valid = 1'b1;
                m_ctl   = ic;
                m_rs    = in_rs;
                m_rt    = in_rt;
                m_dest  = !ic.write_reg ? 5'd0 : (ic.dest_reg == DEST_REG_RD ? in_rd : in_rt);
                m_left  = in_multi ? N : 0;
                exp_q.push_back({ic, in_rs, in_rt, m_dest});
            end else if (leave) begin
                m_valid = 1'b0;
                m_left  = 0;
            end else if (m_left > 0) begin
                m_left--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic control_t mk(input logic wr, input logic dst, input logic [1:0] src,
                                    input logic [1:0] opd, input logic [3:0] alu,
                                    input logic mr, input logic mw);
        control_t c;
        c.write_reg = wr; c.dest_reg = dst; c.reg_src = src; c.opd_use = opd;
        c.alu_op = alu; c.mem_read = mr; c.mem_write = mw;
        return c;
    endfunction

    control_t c_addu, c_lw, c_mult;

    // driver: present an op until it is accepted; report stall cycles
    task automatic send(input control_t c, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic multi, output int stalls);
        in_valid = 1'b1;
        in_ctl   = c;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        in_multi = multi;
        stalls   = 0;
        for (int k = 0; k < 60; k++) begin
            cycle();
            if (last_accept) break;
            stalls++;
        end
        if (!last_accept)
            check("send_timeout", 32'(last_accept), 32'd1);
        in_valid = 1'b0;
        in_multi = 1'b0;
    endtask

    initial begin
        int st;
        int nbusy;
        c_addu = mk(1'b1, DEST_REG_RD, REG_SRC_ALU, OPERAND_USE_RS_RT, 4'h1, 1'b0, 1'b0);
        c_lw   = mk(1'b1, DEST_REG_RT, REG_SRC_MEM, OPERAND_USE_RS,    4'h0, 1'b1, 1'b0);
        c_mult = mk(1'b0, DEST_REG_RD, REG_SRC_ALU, OPERAND_USE_RS_RT, 4'h8, 1'b0, 1'b0);
        model_reset();

        // reset
        repeat (3) cycle();
        check("rst_out_valid", 32'(s_valid), 32'd0);
        check("rst_out_ctl",   32'(out_ctl), 32'd0);
        check("rst_in_ready",  32'(s_in_ready), 32'd0);
        reset_n = 1'b1;
        cycle();

        // plain flow
        out_ready = 1'b1;
        send(c_addu, 5'd1, 5'd2, 5'd3, 1'b0, st);
        check("plain_out_valid", 32'(out_valid), 32'd1);
        check("plain_out_dest",  32'(out_dest),  32'd3);
        for (int i = 0; i < 4; i++) begin
            send(c_addu, 5'(i + 4), 5'(i + 8), 5'(i + 12), 1'b0, st);
            check("b2b_no_stall", 32'(st), 32'd0);
        end
        check("b2b_last_dest", 32'(out_dest), 32'd15);
        repeat (2) cycle();

        // load-use
        send(c_lw, 5'd1, 5'd5, 5'd9, 1'b0, st);
        check("lw_dest_rt", 32'(out_dest), 32'd5);
        send(c_addu, 5'd5, 5'd6, 5'd7, 1'b0, st);
        check("lu_rs_stall", 32'(st), 32'd1);
        check("lu_rs_dest",  32'(out_dest), 32'd7);
        send(c_lw, 5'd1, 5'd5, 5'd9, 1'b0, st);
        send(c_addu, 5'd2, 5'd5, 5'd7, 1'b0, st);
        check("lu_rt_stall", 32'(st), 32'd1);
        send(c_lw, 5'd1, 5'd0, 5'd9, 1'b0, st);
        send(c_addu, 5'd0, 5'd6, 5'd7, 1'b0, st);
        check("lu_zero_no_stall", 32'(st), 32'd0);
        repeat (2) cycle();

        // backpressure
        out_ready = 1'b0;
        send(c_addu, 5'd1, 5'd2, 5'd3, 1'b0, st);
        in_valid = 1'b1; in_ctl = c_addu; in_rs = 5'd4; in_rt = 5'd5; in_rd = 5'd6;
        repeat (3) begin
            cycle();
            check("bp_hold_dest", 32'(out_dest), 32'd3);
            check("bp_in_ready",  32'(s_in_ready), 32'd0);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_release_accept", 32'(s_in_ready), 32'd1);
        check("bp_new_dest",       32'(out_dest),   32'd6);
        in_valid = 1'b0;
        repeat (2) cycle();

        // multi-cycle, EX always ready
        send(c_mult, 5'd1, 5'd2, 5'd0, 1'b1, st);
        nbusy = 0;
        for (int k = 0; k < 100; k++) begin
            cycle();
            if (!s_busy) break;
            nbusy++;
        end
        check("multi_busy_cycles", 32'(nbusy), 32'(N));
        check("multi_after_valid", 32'(s_valid), 32'd0);

        // multi-cycle finishing into backpressure
        out_ready = 1'b0;
        send(c_mult, 5'd3, 5'd4, 5'd0, 1'b1, st);
        repeat (N + 2) cycle();
        check("multi_hold_busy",  32'(busy),      32'd0);
        check("multi_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        repeat (2) cycle();

        // flush during MULTI
        send(c_mult, 5'd3, 5'd4, 5'd0, 1'b1, st);
        repeat (10) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("flush_multi_valid", 32'(out_valid), 32'd0);
        check("flush_multi_busy",  32'(busy),      32'd0);
        check("flush_multi_ctl",   32'(out_ctl),   32'd0);

        // flush while an op is offered
        send(c_addu, 5'd1, 5'd2, 5'd3, 1'b0, st);
        in_valid = 1'b1; in_ctl = c_addu; in_rs = 5'd7; in_rt = 5'd8; in_rd = 5'd9;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_in_ready", 32'(s_in_ready), 32'd0);
        check("flush_in_valid", 32'(out_valid),  32'd0);
        check("flush_in_dest",  32'(out_dest),   32'd0);
        cycle();

        // asynchronous reset mid-MULTI
        send(c_mult, 5'd5, 5'd6, 5'd0, 1'b1, st);
        repeat (5) cycle();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_valid",    32'(out_valid), 32'd0);
        check("async_rst_busy",     32'(busy),      32'd0);
        check("async_rst_ctl",      32'(out_ctl),   32'd0);
        check("async_rst_in_ready", 32'(in_ready),  32'd0);
        cycle();
        reset_n = 1'b1;
        cycle();
        send(c_addu, 5'd1, 5'd2, 5'd3, 1'b0, st);
        check("post_rst_dest", 32'(out_dest), 32'd3);
        repeat (2) cycle();

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
